// File: rtl/clkrst_sequencer.sv
// -----------------------------------------------------------------------------
// clkrst_sequencer
//
// Purpose: from one free-running clock, generates a held system reset,
// staggered per-channel reset releases, per-channel divided clock-enable ticks
// and a run-cycle limiter with a sticky done flag.
//
// Ports:
//   clk          in   system clock, all logic on the rising edge
//   reset        in   synchronous, active-high reset
//   div_ratio    in   NUM_CH*DIV_W, channel i ratio in [i*DIV_W +: DIV_W]
//   ch_en        in   NUM_CH, per-channel tick enable
//   run_limit    in   RUN_W, cycles allowed in RUN (0 = unlimited),
//                     captured on the RELEASE->RUN transition
//   sys_reset_n  out  active-low system reset
//   ch_rst_n     out  NUM_CH, active-low per-channel resets
//   tick         out  NUM_CH, one-cycle clock-enable pulses
//   running      out  high while in RUN
//   done         out  sticky run-complete flag
//   cycle_count  out  RUN_W, cycles spent in RUN, saturating
//
// Handshakes: none; every output is a registered level or one-cycle pulse.
// -----------------------------------------------------------------------------
module clkrst_sequencer #(
    parameter int NUM_CH       = 4,
    parameter int DIV_W        = 8,
    parameter int RESET_CYCLES = 50,
    parameter int STAGGER      = 4,
    parameter int RUN_W        = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH*DIV_W-1:0] div_ratio,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic [RUN_W-1:0]        run_limit,
    output logic                    sys_reset_n,
    output logic [NUM_CH-1:0]       ch_rst_n,
    output logic [NUM_CH-1:0]       tick,
    output logic                    running,
    output logic                    done,
    output logic [RUN_W-1:0]        cycle_count
);

    localparam int HOLD_W  = $clog2(RESET_CYCLES + 1);
    localparam int STG_MAX = STAGGER * NUM_CH;
    localparam int STG_W   = $clog2(STG_MAX + 1);

    typedef enum logic [1:0] {HOLD, RELEASE, RUN, DONE} state_t;

    state_t              state, state_d;
    logic [HOLD_W-1:0]   hold_cnt, hold_cnt_d;
    logic [STG_W-1:0]    stg_cnt, stg_cnt_d, stg_next;
    logic [RUN_W-1:0]    limit_q, limit_d;
    logic [RUN_W-1:0]    cycle_count_d;
    logic                sys_reset_n_d, running_d, done_d;
    logic [NUM_CH-1:0]   ch_rst_n_d, tick_d;
    logic                finish;
    logic [DIV_W-1:0]    div_cnt   [NUM_CH];
    logic [DIV_W-1:0]    div_cnt_d [NUM_CH];
    logic [DIV_W-1:0]    last_val  [NUM_CH];

    // Terminal count per channel: a ratio of 0 behaves as 1.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            last_val[i] = '0;
            if (div_ratio[i*DIV_W +: DIV_W] != '0)
                last_val[i] = div_ratio[i*DIV_W +: DIV_W] - DIV_W'(1);
        end
    end

    // Last RUN edge: the count is one short of a nonzero limit.
    assign finish = (state == RUN) && (limit_q != '0) &&
                    (cycle_count == limit_q - RUN_W'(1));

    always_comb begin
        state_d       = state;
        hold_cnt_d    = hold_cnt;
        stg_cnt_d     = stg_cnt;
        stg_next      = stg_cnt + STG_W'(1);
        limit_d       = limit_q;
        cycle_count_d = cycle_count;
        sys_reset_n_d = sys_reset_n;
        running_d     = running;
        done_d        = done;
        ch_rst_n_d    = ch_rst_n;

        case (state)
            HOLD: begin
                if (hold_cnt == HOLD_W'(RESET_CYCLES)) begin
                    sys_reset_n_d = 1'b1;
                    stg_cnt_d     = '0;
                    state_d       = RELEASE;
                end else begin
                    hold_cnt_d = hold_cnt + HOLD_W'(1);
                end
            end
            RELEASE: begin
                stg_cnt_d = stg_next;
                for (int i = 0; i < NUM_CH; i++) begin
                    if (stg_next == STG_W'(STAGGER * (i + 1)))
                        ch_rst_n_d[i] = 1'b1;
                end
                if (stg_next == STG_W'(STG_MAX)) begin
                    state_d   = RUN;
                    limit_d   = run_limit;
                    running_d = 1'b1;
                end
            end
            RUN: begin
                if (cycle_count != {RUN_W{1'b1}})
                    cycle_count_d = cycle_count + RUN_W'(1);
                if (finish) begin
                    state_d    = DONE;
                    running_d  = 1'b0;
                    done_d     = 1'b1;
                    ch_rst_n_d = '0;
                end
            end
            default: begin
                // DONE: everything holds until reset.
            end
        endcase
    end

    // Dividers. The finishing edge suppresses ticks and clears the counters
    // along with the channel resets.
    always_comb begin
        tick_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            div_cnt_d[i] = '0;
            if (ch_rst_n[i] && ch_en[i] && !finish) begin
                if (div_cnt[i] >= last_val[i]) begin
                    tick_d[i] = 1'b1;
                end else begin
                    div_cnt_d[i] = div_cnt[i] + DIV_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= HOLD;
            hold_cnt    <= '0;
            stg_cnt     <= '0;
            limit_q     <= '0;
            cycle_count <= '0;
            sys_reset_n <= 1'b0;
            running     <= 1'b0;
            done        <= 1'b0;
            ch_rst_n    <= '0;
            tick        <= '0;
            for (int i = 0; i < NUM_CH; i++) div_cnt[i] <= '0;
        end else begin
            state       <= state_d;
            hold_cnt    <= hold_cnt_d;
            stg_cnt     <= stg_cnt_d;
            limit_q     <= limit_d;
            cycle_count <= cycle_count_d;
            sys_reset_n <= sys_reset_n_d;
            running     <= running_d;
            done        <= done_d;
            ch_rst_n    <= ch_rst_n_d;
            tick        <= tick_d;
            for (int i = 0; i < NUM_CH; i++) div_cnt[i] <= div_cnt_d[i];
        end
    end

endmodule

// File: tb/tb_clkrst_sequencer.sv
// -----------------------------------------------------------------------------
// tb_clkrst_sequencer
//
// Bench for clkrst_sequencer. A timeline model predicts every output after
// every edge; predictions are queued when inputs are driven and compared when
// the outputs are sampled on the falling edge. Directed checks cover release
// timing, divide periods, ratio change, enable gating, mid-run reset, the run
// limit and counter saturation (second instance with a 4-bit counter).
// -----------------------------------------------------------------------------
module tb_clkrst_sequencer;

    localparam int RC        = 50;
    localparam int STG       = 4;
    localparam int NCH       = 4;
    localparam int RUN_START = RC + 1 + STG * NCH;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] ratio;
    logic [3:0]  en;
    logic [31:0] lim;

    logic        sys_n, running, done;
    logic [3:0]  chrst, tick;
    logic [31:0] cc;

    logic        s_sys_n, s_running, s_done;
    logic [1:0]  s_chrst, s_tick;
    logic [3:0]  s_cc;

    clkrst_sequencer dut (
        .clk(clk), .reset(rst), .div_ratio(ratio), .ch_en(en), .run_limit(lim),
        .sys_reset_n(sys_n), .ch_rst_n(chrst), .tick(tick), .running(running),
        .done(done), .cycle_count(cc)
    );

    clkrst_sequencer #(.NUM_CH(2), .DIV_W(4), .RESET_CYCLES(2), .STAGGER(1), .RUN_W(4)) dut_s (
        .clk(clk), .reset(rst), .div_ratio(8'h00), .ch_en(2'b00), .run_limit(4'h0),
        .sys_reset_n(s_sys_n), .ch_rst_n(s_chrst), .tick(s_tick), .running(s_running),
        .done(s_done), .cycle_count(s_cc)
    );

    // scoreboard
    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // model
    int          n;
    logic        m_sys, m_run, m_done;
    logic [3:0]  m_chrst, m_tick;
    logic [31:0] m_cc, m_lim;
    int          m_cnt[4];

    // bookkeeping from observed outputs
    int first_sys, first_run, first_tick0;
    int first_ch[4];
    int run_cnt;
    int tick_cnt[4];

    task automatic model_edge();
        logic fin;
        int   r;
        if (rst) begin
            n = 0; m_sys = 0; m_run = 0; m_done = 0; m_chrst = 0; m_tick = 0;
            m_cc = 0; m_lim = 0;
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        end else begin
            n = n + 1;
            fin = !m_done && m_run && (m_lim != 0) && ((n - RUN_START) == int'(m_lim));
            for (int i = 0; i < 4; i++) begin
                r = int'(ratio[i*8 +: 8]);
                if (r == 0) r = 1;
                if (m_chrst[i] && en[i] && !fin && !m_done) begin
                    if (m_cnt[i] >= r - 1) begin
                        m_tick[i] = 1'b1; m_cnt[i] = 0;
                    end else begin
                        m_tick[i] = 1'b0; m_cnt[i] = m_cnt[i] + 1;
                    end
                end else begin
                    m_tick[i] = 1'b0; m_cnt[i] = 0;
                end
            end
            if (fin) begin
                m_done = 1; m_run = 0; m_chrst = 0; m_cc = m_lim;
            end else if (!m_done) begin
                m_sys = (n >= RC + 1);
                for (int i = 0; i < 4; i++) m_chrst[i] = (n >= RC + 1 + STG * (i + 1));
                m_run = (n >= RUN_START);
                if (n == RUN_START) m_lim = lim;
                m_cc = (n > RUN_START) ? 32'(n - RUN_START) : 32'd0;
            end
        end
    endtask

    function automatic logic [63:0] pack(input logic s, input logic [3:0] c, input logic [3:0] t,
                                         input logic r, input logic d, input logic [31:0] k);
        return {21'd0, s, c, t, r, d, k};
    endfunction

    // driver: inputs already set at the falling edge; predict, wait one cycle, compare
    task automatic run_cycle();
        logic [63:0] e;
        model_edge();
        exp_q.push_back(pack(m_sys, m_chrst, m_tick, m_run, m_done, m_cc));
        @(negedge clk);
        if (exp_q.size() == 0) begin
            check("sb_empty", 64'd0, 64'd1);
        end else begin
            e = exp_q.pop_front();
            check("cycle", pack(sys_n, chrst, tick, running, done, cc), e);
        end
        if (!rst) begin
            if (sys_n && first_sys < 0) first_sys = n;
            if (running && first_run < 0) first_run = n;
            if (tick[0] && first_tick0 < 0) first_tick0 = n;
            for (int i = 0; i < 4; i++) begin
                if (chrst[i] && first_ch[i] < 0) first_ch[i] = n;
                tick_cnt[i] += int'(tick[i]);
            end
            run_cnt += int'(running);
        end
    endtask

    task automatic clear_marks();
        first_sys = -1; first_run = -1; first_tick0 = -1; run_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            first_ch[i] = -1; tick_cnt[i] = 0;
        end
    endtask

    task automatic wait_tick0(input int max, output int gap);
        gap = 0;
        for (int k = 1; k <= max; k++) begin
            run_cycle();
            if (tick[0]) begin
                gap = k;
                break;
            end
        end
    endtask

    task automatic check_release();
        check("sys_rise_edges", 64'(first_sys), 64'(RC + 1));
        for (int i = 0; i < 4; i++)
            check("ch_rise_offset", 64'(first_ch[i] - first_sys), 64'(STG * (i + 1)));
        check("run_rise", 64'(first_run), 64'(first_ch[3]));
        check("first_tick0", 64'(first_tick0 - first_ch[0]), 64'd5);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        rst = 1'b1; ratio = {8'd0, 8'd1, 8'd3, 8'd5}; en = 4'hF; lim = 32'd0;
        n = 0;
        clear_marks();
        @(negedge clk);

        // reset state
        repeat (3) run_cycle();
        check("reset_vec", pack(sys_n, chrst, tick, running, done, cc), 64'd0);

        // release sequence and divide ratios
        rst = 1'b0;
        clear_marks();
        repeat (80) run_cycle();
        check_release();
        for (int i = 0; i < 4; i++) tick_cnt[i] = 0;
        repeat (60) run_cycle();
        check("ticks_ch0", 64'(tick_cnt[0]), 64'd12);
        check("ticks_ch1", 64'(tick_cnt[1]), 64'd20);
        check("ticks_ch2", 64'(tick_cnt[2]), 64'd60);
        check("ticks_ch3", 64'(tick_cnt[3]), 64'd60);

        // ratio change: counter at 6 with ratio 10, then ratio 4
        ratio[7:0] = 8'd10;
        wait_tick0(30, g);
        check("ratio10_tick", 64'(g != 0), 64'd1);
        repeat (6) run_cycle();
        ratio[7:0] = 8'd4;
        run_cycle();
        check("ratio4_immediate", 64'(tick[0]), 64'd1);
        wait_tick0(10, g);
        check("ratio4_period", 64'(g), 64'd4);
        wait_tick0(10, g);
        check("ratio4_period", 64'(g), 64'd4);

        // enable gating
        en[0] = 1'b0;
        repeat (2) begin
            run_cycle();
            check("en_off_tick", 64'(tick[0]), 64'd0);
        end
        en[0] = 1'b1;
        wait_tick0(10, g);
        check("reenable_gap", 64'(g), 64'd4);

        // reset in RUN at cycle_count 7
        ratio = {8'd0, 8'd1, 8'd3, 8'd5}; en = 4'hF;
        rst = 1'b1; run_cycle(); rst = 1'b0;
        for (int k = 0; k < 200; k++) begin
            run_cycle();
            if (cc == 32'd7) break;
        end
        check("cc_reached_7", 64'(cc), 64'd7);
        rst = 1'b1; run_cycle();
        check("midrun_reset", pack(sys_n, chrst, tick, running, done, cc), 64'd0);

        // repeated sequence with run limit 20; a later limit change is ignored
        rst = 1'b0; lim = 32'd20;
        clear_marks();
        repeat (70) run_cycle();
        lim = 32'd30;
        repeat (10) run_cycle();
        check_release();
        repeat (30) run_cycle();
        check("run_cycles", 64'(run_cnt), 64'd20);
        check("done_set", 64'(done), 64'd1);
        check("done_cc", 64'(cc), 64'd20);
        check("done_chrst", 64'(chrst), 64'd0);
        check("done_tick", 64'(tick), 64'd0);
        check("done_sys", 64'(sys_n), 64'd1);
        repeat (10) run_cycle();
        check("done_sticky", 64'(done), 64'd1);

        // saturation on the narrow instance
        rst = 1'b1; run_cycle();
        check("sat_reset_cc", 64'(s_cc), 64'd0);
        rst = 1'b0;
        repeat (10) run_cycle();
        check("sat_cc_mid", 64'(s_cc), 64'd5);
        repeat (20) run_cycle();
        check("sat_cc", 64'(s_cc), 64'd15);
        check("sat_running", 64'(s_running), 64'd1);
        check("sat_done", 64'(s_done), 64'd0);
        repeat (5) run_cycle();
        check("sat_hold", 64'(s_cc), 64'd15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clkrst_sequencer.md
Name: clkrst_sequencer

Overview:
Synthesizable, parametrised successor to the testbench clock/reset generator. From one free-running clock it produces:
- a system reset with a programmable hold time;
- per-channel staggered reset releases;
- per-channel divided clock-enable ticks;
- a run-cycle limiter that ends the run with a sticky done flag.

It sits at the top of the PDP8 datapath and feeds reset and enables to the execute, memory and I/O units.

Parameters:
NUM_CH, 4, number of channels (tick and reset outputs), 1..8
DIV_W, 8, width of each channel's divide ratio
RESET_CYCLES, 50, cycles sys_reset_n is held low after reset deasserts, >=1
STAGGER, 4, cycles between successive channel reset releases, >=1
RUN_W, 32, width of the run limit and cycle counter

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
div_ratio  input  NUM_CH*DIV_W  channel i ratio in bits [i*DIV_W +: DIV_W]
ch_en  input  NUM_CH  per-channel tick enable
run_limit  input  RUN_W  cycles allowed in RUN; 0 = unlimited; sampled on the RELEASE->RUN transition
sys_reset_n  output  1  active-low system reset
ch_rst_n  output  NUM_CH  active-low per-channel resets
tick  output  NUM_CH  one-cycle clock-enable pulses
running  output  1  high while in RUN
done  output  1  sticky run-complete flag
cycle_count  output  RUN_W  cycles spent in RUN, saturating

Behaviour:
- Reset is synchronous, active-high. While reset=1, every flop takes its reset value at each edge:
  - state=HOLD, sys_reset_n=0, ch_rst_n=0;
  - tick=0, running=0, done=0, cycle_count=0;
  - all divider and sequence counters = 0.
- Reset asserted mid-operation in any state returns to exactly these values at the next edge.
- All outputs are registered.
- FSM states: HOLD, RELEASE, RUN, DONE.
- HOLD:
  - A hold counter counts cycles after reset deasserts.
  - On the edge where it reaches RESET_CYCLES, sys_reset_n becomes 1 and the FSM enters RELEASE.
  - With reset dropping before edge 0, sys_reset_n is first seen high after edge RESET_CYCLES.
- RELEASE:
  - A stagger counter runs. ch_rst_n[i] rises STAGGER*(i+1) cycles after sys_reset_n rises.
  - Releases are in channel order; once released, a channel stays released until DONE or reset.
  - On the edge that releases channel NUM_CH-1, the FSM enters RUN and latches run_limit.
- RUN:
  - running=1.
  - cycle_count increments every cycle and saturates at all-ones.
  - If the latched limit is nonzero and cycle_count reaches limit-1, the next edge enters DONE; cycle_count then equals the limit.
  - Changes to run_limit during RUN are ignored.
- DONE:
  - running=0, done=1 (sticky), all ch_rst_n=0, tick=0.
  - sys_reset_n stays 1 and cycle_count holds.
  - Only reset leaves DONE.
- Divider, channel i:
  - Active when ch_rst_n[i]=1 and ch_en[i]=1. When inactive, the counter is 0 and tick[i]=0.
  - Effective ratio R = max(div_ratio_i, 1).
  - The counter counts 0..R-1. tick[i] pulses for one cycle on the cycle the counter equals R-1, then the counter wraps to 0.
  - The first tick appears R cycles after activation, and every R cycles after that.
  - R=1 gives tick high every active cycle.
- Ratio change on the fly: if the counter is >= new R-1, tick fires on the next edge and the counter wraps. Otherwise counting continues toward the new R-1.
- ch_en drop: the counter clears on the next edge with no tick. Re-enable restarts the phase from 0.
- Ticks are channel-independent; simultaneous ticks across channels are legal.
- The DONE transition takes priority over any tick that would fire on the same edge: that tick is suppressed.

Test Plan:
- Release sequence. Defaults, reset high for 3 cycles then low.
  - sys_reset_n rises after edge 50.
  - ch_rst_n[0..3] rise at +4, +8, +12, +16 cycles.
  - running rises with ch_rst_n[3].
- Divide ratios. div_ratio={8'd0,8'd1,8'd3,8'd5} for ch3..0, all ch_en=1, run_limit=0.
  - ch0 ticks every 5 cycles; ch1 every 3; ch2 and ch3 every cycle.
  - First ch0 tick comes 5 cycles after its release.
- Run limit. run_limit=20.
  - Exactly 20 cycles with running=1, then done=1 with cycle_count=20.
  - All ch_rst_n=0, no ticks, sys_reset_n=1.
  - done stays high until reset.
- Ratio change and enable gating.
  - ch0 ratio 10 with its counter at 6; change to 4 -> tick on the next edge, then every 4 cycles.
  - Drop ch_en[0] for 2 cycles -> no ticks; re-enable -> first tick 4 cycles later.
- Reset mid-operation. Assert reset during RUN at cycle_count=7.
  - Next edge: all outputs at reset values.
  - After deassert, the full HOLD/RELEASE sequence repeats with identical timing.
- Saturation. RUN_W=4, run_limit=0.
  - cycle_count counts to 15 and holds; running stays 1; done stays 0.
